// File: rtl/fp_align_pipe.sv
// Operand-alignment front end for the IEEE-754 adder: magnitude ordering, effective op,
// guard/round/sticky right shift of the smaller significand and special-value detection.
module fp_align_pipe #(
  parameter  int EXP_SIZE  = 8,
  parameter  int FRAC_SIZE = 23,
  localparam int FP_SIZE   = 1 + EXP_SIZE + FRAC_SIZE,
  localparam int SIG_W     = FRAC_SIZE + 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_SIZE-1:0]  in_a,
  input  logic [FP_SIZE-1:0]  in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_SIZE-1:0] out_exp,
  output logic                out_eff_sub,
  output logic [SIG_W-1:0]    out_sig_big,
  output logic [SIG_W-1:0]    out_sig_small,
  output logic                out_special,
  output logic [FP_SIZE-1:0]  out_special_val
);

  localparam logic [EXP_SIZE-1:0] EXP_ONE = EXP_SIZE'(1);
  localparam logic [FP_SIZE-1:0]  QNAN    = {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(FRAC_SIZE-1){1'b0}}};

  logic                 sign_a, sign_b;
  logic [EXP_SIZE-1:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [FRAC_SIZE-1:0] frac_a, frac_b;
  logic [SIG_W-1:0]     sig_a, sig_b;
  logic                 a_big;
  logic                 nan_a, nan_b, inf_a, inf_b;

  assign sign_a = in_a[FP_SIZE-1];
  assign sign_b = in_b[FP_SIZE-1] ^ in_sub;
  assign exp_a  = in_a[FP_SIZE-2 -: EXP_SIZE];
  assign exp_b  = in_b[FP_SIZE-2 -: EXP_SIZE];
  assign frac_a = in_a[FRAC_SIZE-1:0];
  assign frac_b = in_b[FRAC_SIZE-1:0];

  // Denormals carry no hidden bit but share the exponent of the smallest normal.
  assign eexp_a = (exp_a == '0) ? EXP_ONE : exp_a;
  assign eexp_b = (exp_b == '0) ? EXP_ONE : exp_b;
  assign sig_a  = {exp_a != '0, frac_a, 3'b000};
  assign sig_b  = {exp_b != '0, frac_b, 3'b000};

  // Full {exp,frac} compare so equal exponents still order correctly; ties keep A as big.
  assign a_big = in_a[FP_SIZE-2:0] >= in_b[FP_SIZE-2:0];

  assign nan_a = (&exp_a) && (frac_a != '0);
  assign nan_b = (&exp_b) && (frac_b != '0);
  assign inf_a = (&exp_a) && (frac_a == '0);
  assign inf_b = (&exp_b) && (frac_b == '0);

  // Stage 1 next-state
  logic                sign1_d, eff_sub1_d, special1_d;
  logic [EXP_SIZE-1:0] exp1_d, diff1_d;
  logic [SIG_W-1:0]    sig_big1_d, sig_small1_d;
  logic [FP_SIZE-1:0]  special_val1_d;

  always_comb begin
    sign1_d      = a_big ? sign_a : sign_b;
    exp1_d       = a_big ? eexp_a : eexp_b;
    sig_big1_d   = a_big ? sig_a  : sig_b;
    sig_small1_d = a_big ? sig_b  : sig_a;
    diff1_d      = exp1_d - (a_big ? eexp_b : eexp_a);
    eff_sub1_d   = sign_a ^ sign_b;
  end

  always_comb begin
    special1_d     = 1'b1;
    special_val1_d = '0;
    if (nan_a || nan_b) begin
      special_val1_d = QNAN;
    end else if (inf_a && inf_b && eff_sub1_d) begin
      special_val1_d = QNAN;
    end else if (inf_a) begin
      special_val1_d = {sign_a, {EXP_SIZE{1'b1}}, {FRAC_SIZE{1'b0}}};
    end else if (inf_b) begin
      special_val1_d = {sign_b, {EXP_SIZE{1'b1}}, {FRAC_SIZE{1'b0}}};
    end else begin
      special1_d = 1'b0;
    end
  end

  // Stage 1 registers
  logic                v1_q, sign1_q, eff_sub1_q, special1_q;
  logic [EXP_SIZE-1:0] exp1_q, diff1_q;
  logic [SIG_W-1:0]    sig_big1_q, sig_small1_q;
  logic [FP_SIZE-1:0]  special_val1_q;

  // Stage 2 registers (drive the outputs directly)
  logic                v2_q, sign2_q, eff_sub2_q, special2_q;
  logic [EXP_SIZE-1:0] exp2_q;
  logic [SIG_W-1:0]    sig_big2_q, sig_small2_q;
  logic [FP_SIZE-1:0]  special_val2_q;

  logic rdy1, rdy2;
  assign rdy2     = !v2_q || out_ready;
  assign rdy1     = !v1_q || rdy2;
  assign in_ready = rdy1 && !rst;

  // Shift distances at or beyond SIG_W yield zero shifted bits and an all-ones mask,
  // so the sticky-only result falls out of the same expressions.
  logic [SIG_W-1:0] shifted, lost_mask, sig_small2_d;
  logic             sticky;

  always_comb begin
    shifted      = sig_small1_q >> diff1_q;
    lost_mask    = ~({SIG_W{1'b1}} << diff1_q);
    sticky       = |(sig_small1_q & lost_mask);
    sig_small2_d = shifted | {{(SIG_W-1){1'b0}}, sticky};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q           <= 1'b0;
      sign1_q        <= 1'b0;
      eff_sub1_q     <= 1'b0;
      special1_q     <= 1'b0;
      exp1_q         <= '0;
      diff1_q        <= '0;
      sig_big1_q     <= '0;
      sig_small1_q   <= '0;
      special_val1_q <= '0;
      v2_q           <= 1'b0;
      sign2_q        <= 1'b0;
      eff_sub2_q     <= 1'b0;
      special2_q     <= 1'b0;
      exp2_q         <= '0;
      sig_big2_q     <= '0;
      sig_small2_q   <= '0;
      special_val2_q <= '0;
    end else begin
      if (rdy1) begin
        v1_q <= in_valid;
      end
      if (in_valid && rdy1) begin
        sign1_q        <= sign1_d;
        eff_sub1_q     <= eff_sub1_d;
        special1_q     <= special1_d;
        exp1_q         <= exp1_d;
        diff1_q        <= diff1_d;
        sig_big1_q     <= sig_big1_d;
        sig_small1_q   <= sig_small1_d;
        special_val1_q <= special_val1_d;
      end
      if (rdy2) begin
        v2_q <= v1_q;
      end
      if (v1_q && rdy2) begin
        sign2_q        <= sign1_q;
        eff_sub2_q     <= eff_sub1_q;
        special2_q     <= special1_q;
        exp2_q         <= exp1_q;
        sig_big2_q     <= sig_big1_q;
        sig_small2_q   <= sig_small2_d;
        special_val2_q <= special_val1_q;
      end
    end
  end

  assign out_valid       = v2_q;
  assign out_sign        = sign2_q;
  assign out_exp         = exp2_q;
  assign out_eff_sub     = eff_sub2_q;
  assign out_sig_big     = sig_big2_q;
  assign out_sig_small   = sig_small2_q;
  assign out_special     = special2_q;
  assign out_special_val = special_val2_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe (binary32): expected results queued on input
// transfer, popped and compared on output transfer, plus stall/latency/reset checks.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        out_sign, out_eff_sub, out_special;
  logic [7:0]  out_exp;
  logic [26:0] out_sig_big, out_sig_small;
  logic [31:0] out_special_val;

  always #5 clk = ~clk;

  fp_align_pipe #(.EXP_SIZE(8), .FRAC_SIZE(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_eff_sub(out_eff_sub),
    .out_sig_big(out_sig_big), .out_sig_small(out_sig_small),
    .out_special(out_special), .out_special_val(out_special_val)
  );

  wire [96:0] dut_v = {out_sign, out_exp, out_eff_sub, out_sig_big, out_sig_small,
                       out_special, out_special_val};

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          acc_cnt = 0;
  logic [96:0] exp_q[$];
  logic        held = 1'b0;
  logic [96:0] held_v;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  // Reference: bit-by-bit shift with explicit tally of the bits that fall off.
  function automatic logic [96:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic        sa, sb, a_big, st, spec, nan_a, nan_b, inf_a, inf_b, sign;
    logic [7:0]  ea, eb, ea_e, eb_e, ebig, esml;
    logic [26:0] siga, sigb, sbig, ssml, res;
    logic [31:0] val;
    int          d;
    sa = a[31]; sb = b[31] ^ sub;
    ea = a[30:23]; eb = b[30:23];
    ea_e = (ea == 0) ? 8'd1 : ea;
    eb_e = (eb == 0) ? 8'd1 : eb;
    siga = {(ea != 0), a[22:0], 3'b000};
    sigb = {(eb != 0), b[22:0], 3'b000};
    a_big = (a[30:0] >= b[30:0]);
    if (a_big) begin sign = sa; ebig = ea_e; esml = eb_e; sbig = siga; ssml = sigb; end
    else       begin sign = sb; ebig = eb_e; esml = ea_e; sbig = sigb; ssml = siga; end
    d = int'(ebig) - int'(esml);
    res = '0; st = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (i + d < 27) res[i] = ssml[i + d];
      if (i < d) st = st | ssml[i];
    end
    res[0] = res[0] | st;
    nan_a = (ea == 8'hFF) && (a[22:0] != 0);
    nan_b = (eb == 8'hFF) && (b[22:0] != 0);
    inf_a = (ea == 8'hFF) && (a[22:0] == 0);
    inf_b = (eb == 8'hFF) && (b[22:0] == 0);
    spec = 1'b1; val = 32'h0;
    if (nan_a || nan_b)                    val = 32'h7FC00000;
    else if (inf_a && inf_b && (sa != sb)) val = 32'h7FC00000;
    else if (inf_a)                        val = {sa, 8'hFF, 23'h0};
    else if (inf_b)                        val = {sb, 8'hFF, 23'h0};
    else                                   spec = 1'b0;
    return {sign, ebig, sa ^ sb, sbig, res, spec, val};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0: v[30:0] = '0;
      1: v[30:23] = 8'h00;
      2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  // Monitor/scoreboard at the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (held) chk("stall_hold", 128'(dut_v), 128'(held_v));
        held_v = dut_v;
        held = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 128'(out_valid), 128'(0));
        end else begin
          chk($sformatf("out%0d", n_out), 128'(dut_v), 128'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sub));
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int k;
    k = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] t5_a[5] = '{32'h3F800000, 32'h40000000, 32'hC0A00000, 32'h00000003, 32'h7F800000};
  logic [31:0] t5_b[5] = '{32'h3F000000, 32'hBF800000, 32'h40A00000, 32'h00800000, 32'hFF800000};
  int          start_acc;
  logic        rnd_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_data", 128'(dut_v), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // 1.0 + 1.0: exactly two cycles of latency
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_cycle1", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    chk("lat_cycle2", 128'(out_valid), 128'(1));
    chk("t1_exp", 128'(out_exp), 128'(8'h7F));
    chk("t1_big", 128'(out_sig_big), 128'(27'h4000000));
    chk("t1_small", 128'(out_sig_small), 128'(27'h4000000));

    send(32'h3F800000, 32'h40400000, 1'b1);  // swap, effective subtract
    send(32'h3F800000, 32'h30800000, 1'b0);  // shift beyond width, sticky only
    send(32'h00800000, 32'h00000001, 1'b0);  // denormal small operand
    send(32'h7FC00001, 32'h3F800000, 1'b0);  // NaN
    send(32'h7FA00000, 32'h3F800000, 1'b1);  // signalling NaN quieted
    send(32'h7F800000, 32'h7F800000, 1'b1);  // inf - inf
    send(32'h7F800000, 32'h3F800000, 1'b0);  // inf + finite
    send(32'h3F800000, 32'h7F800000, 1'b1);  // finite - inf
    send(32'h40490FDB, 32'h40490FDB, 1'b0);  // equal magnitudes, A big
    send(32'h3FC00000, 32'hBFA00000, 1'b0);  // same exponent, frac decides
    drain();

    // Back-to-back with a 3-cycle downstream stall
    out_ready = 1'b0;
    start_acc = acc_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) send(t5_a[i], t5_b[i], i[0]);
      end
      begin
        repeat (3) @(negedge clk);
        chk("t5_accepted", 128'(acc_cnt - start_acc), 128'(2));
        chk("t5_in_ready", 128'(in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a, b;
          a = rnd_fp();
          b = rnd_fp();
          if ($urandom_range(0, 2) == 0) b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
          send(a, b, 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two operations in flight
    send(32'h40000000, 32'h3F800000, 1'b0);
    send(32'h41200000, 32'h40A00000, 1'b1);
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_out_valid", 128'(out_valid), 128'(0));
    chk("t6_in_ready_rst", 128'(in_ready), 128'(0));
    exp_q.delete();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", 128'(in_ready), 128'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_stale", 128'(out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
